rf_minmax_scanner: RTL and testbench
====================================

Name: rf_minmax_scanner

Overview:
- Read-side master for the 8x16 register file write interface (clk, WriteEn, WriteReg, WriteData).
- After the file is loaded, Start launches a sequential scan: one register address is driven per cycle onto the file's combinational read port.
- Running unsigned max/min are accumulated; Valid is raised once every register has been compared.
- Sits beside the register file; consumed by display/compare logic that expects Max/Min/Valid.

Parameters:
- DATA_W, 16, register data width.
- ADDR_W, 3, register address width.
- NUM_REGS, 8, registers scanned (indices 0..NUM_REGS-1); must satisfy 1 <= NUM_REGS <= 2**ADDR_W.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- Start  input  1  scan request, sampled only in IDLE or DONE.
- ReadEn  output  1  high while a read address is presented.
- ReadReg  output  ADDR_W  read address to register file.
- ReadData  input  DATA_W  combinational read data for ReadReg, same cycle.
- Max  output  DATA_W  largest value scanned.
- Min  output  DATA_W  smallest value scanned.
- Busy  output  1  scan in progress.
- Valid  output  1  Max/Min complete and stable.

Interface (already decided): one clock; reset is synchronous and active-high (ports clk and rst).

Behaviour:
- Reset (rst high at a clk edge): state=IDLE; ReadEn=0, ReadReg=0, Max=0, Min=0, Busy=0, Valid=0. rst has priority over every other input, including mid-scan; a partial scan is discarded.
- States: IDLE, SCAN, DONE.
  - IDLE: Start=1 at edge E0 -> SCAN; ReadReg=0, ReadEn=1, Busy=1, Valid=0.
  - SCAN, at each edge:
    - capture ReadData for the current ReadReg.
    - Index 0 initialises Max=Min=ReadData.
    - Later indices: Max updates if ReadData > Max; Min updates if ReadData < Min.
    - Comparison is unsigned, full DATA_W. Ties keep the held value.
    - If ReadReg == NUM_REGS-1: -> DONE, ReadEn=0, Busy=0, Valid=1. Otherwise ReadReg += 1.
  - DONE: Valid, Max and Min hold indefinitely. Start=1 -> SCAN exactly as from IDLE; Valid drops in the same edge.
- Latency: Valid first seen high after edge E0+NUM_REGS. For defaults, Start sampled at E0 gives Valid after E8.
- Start while in SCAN is ignored; there is no queuing.
- ReadReg never exceeds NUM_REGS-1 and does not wrap; it holds its last value in DONE and IDLE with ReadEn=0.
- Max/Min change only in SCAN. During a scan they are intermediate values and are qualified only by Valid.
- Register-file writes during SCAN are not blocked. Data read after a write reflects the new value; consistency is the system's responsibility.

Optional Feature:
- Macro: RF_SCAN_INDEX_EN.
- Defined: adds outputs MaxIdx and MinIdx (ADDR_W each).
  - Hold the index of the winning register; ties keep the lower index.
  - Reset to 0; valid with Valid.
- Undefined: ports absent; no index registers synthesised.

Decomposition:
- Package rf_scan_pkg holds:
  - DATA_W/ADDR_W/NUM_REGS defaults.
  - scan state enum (IDLE, SCAN, DONE).
  - reset constants for outputs.
- Sub-module minmax_update is combinational: current Max/Min (+ indices), new sample, first flag -> next Max/Min (+ indices). It is instantiated once in the scanner; FSM and counter stay in the top.

Test Plan:
- Load reg k = k (0..7), pulse Start -> ReadReg steps 0..7 one per cycle; Valid after 8 edges; Max=0x0007, Min=0x0000.
- Load descending 0xFFFF,0x8000,...,0x0001 with Min at index 7 -> Max=0xFFFF, Min=0x0001 (unsigned; 0x8000 not treated as negative).
- All regs 0x5A5A -> Max=Min=0x5A5A; with RF_SCAN_INDEX_EN, MaxIdx=MinIdx=0.
- Start re-pulsed at scan cycle 3 -> ignored; Valid still exactly 8 edges after the original Start. Start from DONE after changing reg 4 to 0x00FF -> Valid drops, new result after 8 edges.
- rst high at scan cycle 5 -> next cycle IDLE, all outputs 0, Busy=0. A subsequent Start gives a full correct scan.
- rst during DONE -> Valid=0, Max=Min=0; Start held low -> outputs stay 0, ReadEn stays 0.

Source files
------------

// File: rtl/rf_scan_pkg.sv
// Shared defaults, scan state encoding and output reset values for the
// register-file min/max scanner.
package rf_scan_pkg;

  localparam int DEF_DATA_W   = 16;
  localparam int DEF_ADDR_W   = 3;
  localparam int DEF_NUM_REGS = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } scan_state_t;

  localparam logic                  RST_READ_EN = 1'b0;
  localparam logic                  RST_BUSY    = 1'b0;
  localparam logic                  RST_VALID   = 1'b0;
  localparam logic [DEF_DATA_W-1:0] RST_DATA    = '0;
  localparam logic [DEF_ADDR_W-1:0] RST_ADDR    = '0;

endpackage

// File: rtl/minmax_update.sv
// Combinational running max/min step: folds one unsigned sample into the held
// extremes. Index tracking is present only when RF_SCAN_INDEX_EN is defined.
module minmax_update #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
) (
  input  logic [DATA_W-1:0] cur_max,
  input  logic [DATA_W-1:0] cur_min,
  input  logic [DATA_W-1:0] sample,
  input  logic              first,
  output logic [DATA_W-1:0] next_max,
  output logic [DATA_W-1:0] next_min
`ifdef RF_SCAN_INDEX_EN
  ,
  input  logic [ADDR_W-1:0] cur_max_idx,
  input  logic [ADDR_W-1:0] cur_min_idx,
  input  logic [ADDR_W-1:0] sample_idx,
  output logic [ADDR_W-1:0] next_max_idx,
  output logic [ADDR_W-1:0] next_min_idx
`endif
);

  // Strict compares so a tie keeps the held value (and its lower index).
  always_comb begin
    next_max = cur_max;
    next_min = cur_min;
`ifdef RF_SCAN_INDEX_EN
    next_max_idx = cur_max_idx;
    next_min_idx = cur_min_idx;
`endif
    if (first) begin
      next_max = sample;
      next_min = sample;
`ifdef RF_SCAN_INDEX_EN
      next_max_idx = sample_idx;
      next_min_idx = sample_idx;
`endif
    end else begin
      if (sample > cur_max) begin
        next_max = sample;
`ifdef RF_SCAN_INDEX_EN
        next_max_idx = sample_idx;
`endif
      end
      if (sample < cur_min) begin
        next_min = sample;
`ifdef RF_SCAN_INDEX_EN
        next_min_idx = sample_idx;
`endif
      end
    end
  end

endmodule

// File: rtl/rf_minmax_scanner.sv
// Sequentially reads every register of the file and reports unsigned Max/Min.
// Define RF_SCAN_INDEX_EN to also report the winning register indices.
module rf_minmax_scanner
  import rf_scan_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int NUM_REGS = DEF_NUM_REGS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              Start,
  output logic              ReadEn,
  output logic [ADDR_W-1:0] ReadReg,
  input  logic [DATA_W-1:0] ReadData,
  output logic [DATA_W-1:0] Max,
  output logic [DATA_W-1:0] Min,
  output logic              Busy,
  output logic              Valid
`ifdef RF_SCAN_INDEX_EN
  ,
  output logic [ADDR_W-1:0] MaxIdx,
  output logic [ADDR_W-1:0] MinIdx
`endif
);

  localparam logic [ADDR_W-1:0] LAST_REG = ADDR_W'(NUM_REGS - 1);

  scan_state_t       state;
  logic [DATA_W-1:0] next_max;
  logic [DATA_W-1:0] next_min;
  logic              first;

  assign first = (ReadReg == '0);

`ifdef RF_SCAN_INDEX_EN
  logic [ADDR_W-1:0] next_max_idx;
  logic [ADDR_W-1:0] next_min_idx;
`endif

  minmax_update #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_update (
    .cur_max      (Max),
    .cur_min      (Min),
    .sample       (ReadData),
    .first        (first),
    .next_max     (next_max),
    .next_min     (next_min)
`ifdef RF_SCAN_INDEX_EN
    ,
    .cur_max_idx  (MaxIdx),
    .cur_min_idx  (MinIdx),
    .sample_idx   (ReadReg),
    .next_max_idx (next_max_idx),
    .next_min_idx (next_min_idx)
`endif
  );

  // Scan FSM: a scan always starts at index 0, so index 0 doubles as the
  // "first sample" flag that seeds Max/Min.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      ReadEn  <= RST_READ_EN;
      ReadReg <= ADDR_W'(RST_ADDR);
      Max     <= DATA_W'(RST_DATA);
      Min     <= DATA_W'(RST_DATA);
      Busy    <= RST_BUSY;
      Valid   <= RST_VALID;
`ifdef RF_SCAN_INDEX_EN
      MaxIdx  <= ADDR_W'(RST_ADDR);
      MinIdx  <= ADDR_W'(RST_ADDR);
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          if (Start) begin
            state   <= SCAN;
            ReadReg <= '0;
            ReadEn  <= 1'b1;
            Busy    <= 1'b1;
            Valid   <= 1'b0;
          end
        end
        SCAN: begin
          Max <= next_max;
          Min <= next_min;
`ifdef RF_SCAN_INDEX_EN
          MaxIdx <= next_max_idx;
          MinIdx <= next_min_idx;
`endif
          if (ReadReg == LAST_REG) begin
            state  <= DONE;
            ReadEn <= 1'b0;
            Busy   <= 1'b0;
            Valid  <= 1'b1;
          end else begin
            ReadReg <= ReadReg + ADDR_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rf_minmax_scanner.sv
// Directed bench for rf_minmax_scanner with a behavioural 8x16 register file.
// Index outputs are checked when RF_SCAN_INDEX_EN is defined.
module tb_rf_minmax_scanner;

  logic        clk;
  logic        rst;
  logic        Start;
  logic        ReadEn;
  logic [2:0]  ReadReg;
  logic [15:0] ReadData;
  logic [15:0] Max;
  logic [15:0] Min;
  logic        Busy;
  logic        Valid;
`ifdef RF_SCAN_INDEX_EN
  logic [2:0]  MaxIdx;
  logic [2:0]  MinIdx;
`endif

  logic [15:0] rf [8];
  int checks = 0;
  int errors = 0;

  assign ReadData = rf[ReadReg];

  rf_minmax_scanner dut (
    .clk      (clk),
    .rst      (rst),
    .Start    (Start),
    .ReadEn   (ReadEn),
    .ReadReg  (ReadReg),
    .ReadData (ReadData),
    .Max      (Max),
    .Min      (Min),
    .Busy     (Busy),
    .Valid    (Valid)
`ifdef RF_SCAN_INDEX_EN
    ,
    .MaxIdx   (MaxIdx),
    .MinIdx   (MinIdx)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_scan();
    Start = 1'b1;
    step();
    Start = 1'b0;
  endtask

  // Counts edges until Valid rises, bounded so a stuck DUT cannot hang the run.
  task automatic wait_valid(output int n);
    n = 0;
    while (!Valid && n < 20) begin
      step();
      n++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    Start = 1'b0;
    step();
    step();
    rst = 1'b0;
    checks++;
    if ({ReadEn, ReadReg, Max, Min, Busy, Valid} !== 38'd0) begin
      errors++;
      $display("[TB] FAIL reset_state: got en=%b reg=%0d max=%h min=%h busy=%b valid=%b, want all 0",
               ReadEn, ReadReg, Max, Min, Busy, Valid);
    end
  endtask

  task automatic test_ascending();
    for (int k = 0; k < 8; k++) rf[k] = 16'(k);
    start_scan();
    checks++;
    if (ReadEn !== 1'b1 || Busy !== 1'b1 || ReadReg !== 3'd0 || Valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL asc_start: got en=%b busy=%b reg=%0d valid=%b, want 1 1 0 0",
               ReadEn, Busy, ReadReg, Valid);
    end
    for (int i = 1; i < 8; i++) begin
      step();
      checks++;
      if (ReadReg !== 3'(i) || Valid !== 1'b0) begin
        errors++;
        $display("[TB] FAIL asc_step%0d: got reg=%0d valid=%b, want reg=%0d valid=0",
                 i, ReadReg, Valid, i);
      end
    end
    step();
    checks++;
    if (Valid !== 1'b1 || Busy !== 1'b0 || ReadEn !== 1'b0 || ReadReg !== 3'd7 ||
        Max !== 16'h0007 || Min !== 16'h0000) begin
      errors++;
      $display("[TB] FAIL asc_done: got valid=%b busy=%b en=%b reg=%0d max=%h min=%h, want 1 0 0 7 0007 0000",
               Valid, Busy, ReadEn, ReadReg, Max, Min);
    end
  endtask

  task automatic test_descending();
    int n;
    rf[0] = 16'hFFFF; rf[1] = 16'h8000; rf[2] = 16'h4000; rf[3] = 16'h2000;
    rf[4] = 16'h1000; rf[5] = 16'h0100; rf[6] = 16'h0010; rf[7] = 16'h0001;
    start_scan();
    wait_valid(n);
    checks++;
    if (n !== 8 || Max !== 16'hFFFF || Min !== 16'h0001) begin
      errors++;
      $display("[TB] FAIL desc: got edges=%0d max=%h min=%h, want 8 ffff 0001", n, Max, Min);
    end
`ifdef RF_SCAN_INDEX_EN
    checks++;
    if (MaxIdx !== 3'd0 || MinIdx !== 3'd7) begin
      errors++;
      $display("[TB] FAIL desc_idx: got maxidx=%0d minidx=%0d, want 0 7", MaxIdx, MinIdx);
    end
`endif
  endtask

  task automatic test_all_equal();
    int n;
    for (int k = 0; k < 8; k++) rf[k] = 16'h5A5A;
    start_scan();
    checks++;
    if (Valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL eq_valid_drop: got valid=%b, want 0", Valid);
    end
    wait_valid(n);
    checks++;
    if (n !== 8 || Max !== 16'h5A5A || Min !== 16'h5A5A) begin
      errors++;
      $display("[TB] FAIL equal: got edges=%0d max=%h min=%h, want 8 5a5a 5a5a", n, Max, Min);
    end
`ifdef RF_SCAN_INDEX_EN
    checks++;
    if (MaxIdx !== 3'd0 || MinIdx !== 3'd0) begin
      errors++;
      $display("[TB] FAIL equal_idx: got maxidx=%0d minidx=%0d, want 0 0", MaxIdx, MinIdx);
    end
`endif
  endtask

  task automatic test_back_to_back();
    int n;
    for (int k = 0; k < 8; k++) rf[k] = 16'(k);
    start_scan();
    step();
    step();
    Start = 1'b1;
    step();
    Start = 1'b0;
    wait_valid(n);
    checks++;
    if (n !== 5 || Max !== 16'h0007 || Min !== 16'h0000) begin
      errors++;
      $display("[TB] FAIL restart_ignored: got edges_after_e3=%0d max=%h min=%h, want 5 0007 0000",
               n, Max, Min);
    end
    for (int i = 0; i < 3; i++) step();
    checks++;
    if (Valid !== 1'b1 || Max !== 16'h0007 || Min !== 16'h0000 || ReadReg !== 3'd7) begin
      errors++;
      $display("[TB] FAIL done_hold: got valid=%b max=%h min=%h reg=%0d, want 1 0007 0000 7",
               Valid, Max, Min, ReadReg);
    end
    rf[4] = 16'h00FF;
    start_scan();
    checks++;
    if (Valid !== 1'b0 || Busy !== 1'b1 || ReadReg !== 3'd0) begin
      errors++;
      $display("[TB] FAIL done_restart: got valid=%b busy=%b reg=%0d, want 0 1 0", Valid, Busy, ReadReg);
    end
    wait_valid(n);
    checks++;
    if (n !== 8 || Max !== 16'h00FF || Min !== 16'h0000) begin
      errors++;
      $display("[TB] FAIL rescan: got edges=%0d max=%h min=%h, want 8 00ff 0000", n, Max, Min);
    end
  endtask

  task automatic test_reset_mid_scan();
    int n;
    start_scan();
    for (int i = 0; i < 5; i++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if ({ReadEn, ReadReg, Max, Min, Busy, Valid} !== 38'd0) begin
      errors++;
      $display("[TB] FAIL mid_reset: got en=%b reg=%0d max=%h min=%h busy=%b valid=%b, want all 0",
               ReadEn, ReadReg, Max, Min, Busy, Valid);
    end
    step();
    checks++;
    if (Busy !== 1'b0 || ReadEn !== 1'b0) begin
      errors++;
      $display("[TB] FAIL mid_reset_idle: got busy=%b en=%b, want 0 0", Busy, ReadEn);
    end
    start_scan();
    wait_valid(n);
    checks++;
    if (n !== 8 || Max !== 16'h00FF || Min !== 16'h0000) begin
      errors++;
      $display("[TB] FAIL post_reset_scan: got edges=%0d max=%h min=%h, want 8 00ff 0000", n, Max, Min);
    end
  endtask

  task automatic test_reset_in_done();
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if (Valid !== 1'b0 || Max !== 16'h0000 || Min !== 16'h0000) begin
      errors++;
      $display("[TB] FAIL done_reset: got valid=%b max=%h min=%h, want 0 0000 0000", Valid, Max, Min);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (ReadEn !== 1'b0 || Valid !== 1'b0 || Max !== 16'h0000 || Min !== 16'h0000 || Busy !== 1'b0) begin
        errors++;
        $display("[TB] FAIL idle_hold%0d: got en=%b valid=%b max=%h min=%h busy=%b, want all 0",
                 i, ReadEn, Valid, Max, Min, Busy);
      end
    end
  endtask

  initial begin
    rst   = 1'b1;
    Start = 1'b0;
    for (int k = 0; k < 8; k++) rf[k] = '0;
    test_reset();
    test_ascending();
    test_descending();
    test_all_equal();
    test_back_to_back();
    test_reset_mid_scan();
    test_reset_in_done();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
